// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if : level-held en/fin request/response bundle between ALU and divider
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             fin;
  logic             div_by_zero;

  modport master (
    output en, signed_mode, dividend, divisor,
    input  quotient, remainder, fin, div_by_zero
  );

  modport slave (
    input  en, signed_mode, dividend, divisor,
    output quotient, remainder, fin, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider : restoring divider, one quotient bit per clock, signed/unsigned
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_fin;
  logic             r_dbz;
  logic [CNT_W-1:0] r_cnt;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_dividend_mag;
  logic [WIDTH-1:0] w_divisor_mag;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_quo;

  always_comb begin
    w_a_neg        = bus.signed_mode & bus.dividend[WIDTH-1];
    w_b_neg        = bus.signed_mode & bus.divisor[WIDTH-1];
    w_dividend_mag = w_a_neg ? -bus.dividend : bus.dividend;
    w_divisor_mag  = w_b_neg ? -bus.divisor  : bus.divisor;
    // One extra bit on the trial subtract keeps divisors with the MSB set exact.
    w_shifted      = {r_rem, r_quo[WIDTH-1]};
    w_trial        = w_shifted - {1'b0, r_dvs};
    if (w_trial[WIDTH]) begin
      w_next_rem = w_shifted[WIDTH-1:0];
      w_next_quo = {r_quo[WIDTH-2:0], 1'b0};
    end else begin
      w_next_rem = w_trial[WIDTH-1:0];
      w_next_quo = {r_quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_fin       <= 1'b0;
      r_dbz       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_fin <= 1'b0;
          if (bus.en) begin
            r_rem   <= '0;
            r_quo   <= w_dividend_mag;
            r_dvs   <= w_divisor_mag;
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
            r_cnt   <= '0;
            if (bus.divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_dbz       <= 1'b1;
              r_fin       <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_dbz   <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (!bus.en) begin
            r_state <= S_IDLE;
          end else begin
            r_rem <= w_next_rem;
            r_quo <= w_next_quo;
            r_cnt <= r_cnt + CNT_W'(1);
            // Truncating division: quotient sign from operand XOR, remainder follows dividend.
            if (r_cnt == CNT_LAST) begin
              r_quotient  <= r_q_neg ? -w_next_quo : w_next_quo;
              r_remainder <= r_r_neg ? -w_next_rem : w_next_rem;
              r_fin       <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!bus.en) begin
            r_fin   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_fin   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.fin         = r_fin;
  assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider : scoreboard bench for seq_divider (WIDTH=32)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;
  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;
  exp_t sb[$];

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.dbz = 1'b0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (!sm) begin
      e.q = a / b;
      e.r = a % b;
    end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      e.q = a;
      e.r = '0;
    end else begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end
    return e;
  endfunction

  // Full request: expected pushed at drive time, popped when fin appears.
  task automatic run_op(input string name, input logic sm, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit scramble);
    exp_t e;
    int   lat;
    int   want_lat;
    sb.push_back(model(sm, a, b));
    want_lat = (b == '0) ? 1 : LAT;
    @(negedge clk);
    bus.en = 1'b1; bus.signed_mode = sm; bus.dividend = a; bus.divisor = b;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (scramble) begin
        bus.dividend = $urandom; bus.divisor = $urandom; bus.signed_mode = ~sm;
      end
    end while (!bus.fin && lat < LAT + 8);
    e = sb.pop_front();
    checks++;
    if (lat !== want_lat) begin
      fails++; $display("FAIL %s latency: got %0d clocks, expected %0d", name, lat, want_lat);
    end
    checks++;
    if (bus.quotient !== e.q) begin
      fails++; $display("FAIL %s quotient: got %h, expected %h", name, bus.quotient, e.q);
    end
    checks++;
    if (bus.remainder !== e.r) begin
      fails++; $display("FAIL %s remainder: got %h, expected %h", name, bus.remainder, e.r);
    end
    checks++;
    if (bus.div_by_zero !== e.dbz) begin
      fails++; $display("FAIL %s div_by_zero: got %b, expected %b", name, bus.div_by_zero, e.dbz);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.fin !== 1'b1 || bus.quotient !== e.q || bus.remainder !== e.r) begin
      fails++; $display("FAIL %s hold: got fin=%b q=%h r=%h, expected fin=1 q=%h r=%h",
                        name, bus.fin, bus.quotient, bus.remainder, e.q, e.r);
    end
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.fin !== 1'b0) begin
      fails++; $display("FAIL %s fin_drop: got %b, expected 0", name, bus.fin);
    end
  endtask

  task automatic test_reset;
    bus.en = 1'b0; bus.signed_mode = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst = 1'b1;
    #12;
    checks++;
    if (bus.quotient !== '0 || bus.remainder !== '0 || bus.fin !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      fails++; $display("FAIL reset: got q=%h r=%h fin=%b dbz=%b, expected all 0",
                        bus.quotient, bus.remainder, bus.fin, bus.div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    run_op("u_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    run_op("u_ffff_8000", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("u_zero_dividend", 1'b0, 32'd0, 32'd13, 1'b0);
    run_op("u_big_div", 1'b0, 32'h7FFF_FFFF, 32'hC000_0001, 1'b0);
  endtask

  task automatic test_signed;
    run_op("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
    run_op("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 1'b0);
    run_op("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0);
    run_op("s_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("s_m100_7_in_unsigned", 1'b0, 32'hFFFF_FF9C, 32'd7, 1'b0);
  endtask

  task automatic test_div_zero;
    run_op("dz_unsigned", 1'b0, 32'd5, 32'd0, 1'b0);
    run_op("dz_signed", 1'b1, 32'd5, 32'd0, 1'b0);
    run_op("dz_neg", 1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0);
  endtask

  task automatic test_operand_hold;
    run_op("hold_ops", 1'b1, 32'hFFFF_D8F1, 32'd123, 1'b1);
  endtask

  task automatic test_abort;
    bit seen = 1'b0;
    @(negedge clk);
    bus.en = 1'b1; bus.signed_mode = 1'b0; bus.dividend = 32'd1234; bus.divisor = 32'd5;
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.fin !== 1'b0) begin
      fails++; $display("FAIL abort_idle: got fin=%b, expected 0", bus.fin);
    end
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.fin) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      fails++; $display("FAIL abort_no_fin: got fin rising, expected none");
    end
    run_op("abort_retry_9_3", 1'b0, 32'd9, 32'd3, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (i == 2) b = 32'h8000_0000 | $urandom;
      run_op("random", i[0], a, b, 1'b0);
    end
  endtask

  task automatic test_async_reset;
    run_op("pre_rst", 1'b0, 32'd1000, 32'd7, 1'b0);
    @(negedge clk);
    bus.en = 1'b1; bus.signed_mode = 1'b0; bus.dividend = 32'd77777; bus.divisor = 32'd13;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.quotient !== '0 || bus.remainder !== '0 || bus.fin !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      fails++; $display("FAIL async_rst: got q=%h r=%h fin=%b dbz=%b, expected all 0",
                        bus.quotient, bus.remainder, bus.fin, bus.div_by_zero);
    end
    @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 1'b1, 32'hFFFF_FC18, 32'd7, 1'b0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_operand_hold();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
